// File: rtl/systolic_pe.sv
// systolic_pe -- one processing element of a systolic multiply-accumulate array.
//
// Operands arriving from the west (x_i) and north (y_i) are multiplied and
// accumulated into a dot product, while the operands themselves are passed on
// to the east (x_o) and south (y_o) neighbours one cycle later. A beat tagged
// with last_i closes the dot product and moves the sum into a result register
// that a downstream consumer drains with a valid/ready handshake.
//
// Optional feature macro: PE_SAT_EN
//   defined   -> accumulation adds clamp to the ACC_W range and ovf_o flags any
//                result that clamped at least once
//   undefined -> adds wrap modulo 2^ACC_W and ovf_o is always 0
//
// Parameters:
//   DATA_W  operand width
//   ACC_W   accumulator / result width (must be >= 2*DATA_W)
//   SIGNED  0 = unsigned arithmetic, 1 = two's-complement arithmetic
//
// Ports:
//   clk        in   1       clock, rising-edge
//   rst        in   1       synchronous active-high reset
//   x_i        in   DATA_W  row operand
//   y_i        in   DATA_W  column operand
//   vld_i      in   1       x_i/y_i pair valid
//   last_i     in   1       final pair of the dot product (qualified by vld_i)
//   clr_i      in   1       abandon accumulation in progress, clear ovr_o
//   x_o        out  DATA_W  x_i delayed one cycle
//   y_o        out  DATA_W  y_i delayed one cycle
//   vld_o      out  1       vld_i delayed one cycle
//   last_o     out  1       last_i delayed one cycle
//   res_o      out  ACC_W   completed dot product
//   res_vld_o  out  1       res_o holds an unconsumed result
//   res_rdy_i  in   1       consumer takes res_o this cycle
//   ovf_o      out  1       res_o saturated
//   ovr_o      out  1       sticky: an unconsumed result was overwritten
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+4,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic              vld_i,
  input  logic              last_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] x_o,
  output logic [DATA_W-1:0] y_o,
  output logic              vld_o,
  output logic              last_o,
  output logic [ACC_W-1:0]  res_o,
  output logic              res_vld_o,
  input  logic              res_rdy_i,
  output logic              ovf_o,
  output logic              ovr_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_accNext;
  logic                r_accOvf;
  logic                w_accOvfNext;

  logic [DATA_W-1:0]   r_x;
  logic [DATA_W-1:0]   r_y;
  logic                r_vld;
  logic                r_last;

  logic [ACC_W-1:0]    r_res;
  logic                r_resVld;
  logic                r_ovf;
  logic                r_ovr;

  logic signed [2*DATA_W-1:0] w_prodS;
  logic [2*DATA_W-1:0]        w_prodU;
  logic [2*DATA_W-1:0]        w_prodFull;
  logic [ACC_W-1:0]           w_prodExt;
  logic [ACC_W-1:0]           w_addSum;
  logic                       w_addOvf;

  logic                w_fromEmpty;
  logic [ACC_W-1:0]    w_beatSum;
  logic                w_beatOvf;
  logic                w_load;

  // Full-width product; the signed form is only selected when SIGNED is set.
  // Widening to ACC_W sign-extends or zero-extends to match the arithmetic.
  assign w_prodS    = $signed(x_i) * $signed(y_i);
  assign w_prodU    = x_i * y_i;
  assign w_prodFull = (SIGNED != 0) ? w_prodS : w_prodU;
  assign w_prodExt  = (SIGNED != 0) ? ACC_W'($signed(w_prodFull))
                                    : ACC_W'(w_prodFull);

`ifdef PE_SAT_EN
  // One extra bit of headroom exposes the carry (unsigned) or the sign
  // disagreement (signed) that marks an out-of-range sum.
  logic               w_accTop;
  logic               w_prodTop;
  logic [ACC_W:0]     w_addWide;
  logic [ACC_W-1:0]   w_maxVal;
  logic [ACC_W-1:0]   w_minVal;

  assign w_accTop  = (SIGNED != 0) ? r_acc[ACC_W-1] : 1'b0;
  assign w_prodTop = (SIGNED != 0) ? w_prodExt[ACC_W-1] : 1'b0;
  assign w_addWide = {w_accTop, r_acc} + {w_prodTop, w_prodExt};
  assign w_maxVal  = (SIGNED != 0) ? {1'b0, {(ACC_W-1){1'b1}}} : {ACC_W{1'b1}};
  assign w_minVal  = (SIGNED != 0) ? {1'b1, {(ACC_W-1){1'b0}}} : {ACC_W{1'b0}};
  assign w_addOvf  = (SIGNED != 0) ? (w_addWide[ACC_W] != w_addWide[ACC_W-1])
                                   : w_addWide[ACC_W];
  // A signed overflow with a negative wide sum went below the minimum.
  assign w_addSum  = !w_addOvf ? w_addWide[ACC_W-1:0]
                   : ((SIGNED != 0) && w_addWide[ACC_W]) ? w_minVal
                   : w_maxVal;
`else
  assign w_addOvf  = 1'b0;
  assign w_addSum  = r_acc + w_prodExt;
`endif

  // Next-state logic for the accumulator. clr_i makes the current beat look
  // like the first beat of a fresh dot product, so the old partial sum and its
  // overflow history are simply ignored rather than cleared first.
  always_comb begin
    w_stateNext  = r_state;
    w_accNext    = r_acc;
    w_accOvfNext = r_accOvf;
    w_load       = 1'b0;
    w_fromEmpty  = clr_i || (r_state == EMPTY);
    w_beatSum    = w_fromEmpty ? w_prodExt : w_addSum;
    w_beatOvf    = w_fromEmpty ? 1'b0 : (r_accOvf | w_addOvf);
    if (clr_i) begin
      w_stateNext  = EMPTY;
      w_accNext    = '0;
      w_accOvfNext = 1'b0;
    end
    if (vld_i) begin
      if (last_i) begin
        w_load       = 1'b1;
        w_stateNext  = EMPTY;
        w_accNext    = '0;
        w_accOvfNext = 1'b0;
      end else begin
        w_stateNext  = ACCUM;
        w_accNext    = w_beatSum;
        w_accOvfNext = w_beatOvf;
      end
    end
  end

  // Accumulator and FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_acc    <= '0;
      r_accOvf <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_acc    <= w_accNext;
      r_accOvf <= w_accOvfNext;
    end
  end

  // Neighbour pass-through: a plain one-cycle delay that never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_vld  <= 1'b0;
      r_last <= 1'b0;
    end else begin
      r_x    <= x_i;
      r_y    <= y_i;
      r_vld  <= vld_i;
      r_last <= last_i;
    end
  end

  // Result register with handshake. A new result always wins: if the old one
  // is being consumed the same cycle it is a clean hand-over, otherwise the old
  // one is lost and ovr_o latches. An overrun in the same cycle as clr_i still
  // sets ovr_o, since it happened after the clear took effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res    <= '0;
      r_resVld <= 1'b0;
      r_ovf    <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (clr_i) begin
        r_ovr <= 1'b0;
      end
      if (w_load) begin
        r_res    <= w_beatSum;
        r_resVld <= 1'b1;
        r_ovf    <= w_beatOvf;
        if (r_resVld && !res_rdy_i) begin
          r_ovr <= 1'b1;
        end
      end else if (r_resVld && res_rdy_i) begin
        r_resVld <= 1'b0;
      end
    end
  end

  assign x_o       = r_x;
  assign y_o       = r_y;
  assign vld_o     = r_vld;
  assign last_o    = r_last;
  assign res_o     = r_res;
  assign res_vld_o = r_resVld;
  assign ovf_o     = r_ovf;
  assign ovr_o     = r_ovr;

endmodule

// File: doc/systolic_pe.md
SYSTOLIC_PE -- requirements
Module: systolic_pe

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the operand width of x_i, y_i, x_o and y_o.
REQ-002 Parameter ACC_W, default 2*DATA_W+4, SHALL set the accumulator and result width; legal only when ACC_W >= 2*DATA_W.
REQ-003 Parameter SIGNED, default 0, SHALL select unsigned (0) or two's-complement (1) operands, product and accumulator.
REQ-004 The ports SHALL be as follows:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- x_i  in  DATA_W  row operand.
- y_i  in  DATA_W  column operand.
- vld_i  in  1  x_i/y_i pair valid this cycle.
- last_i  in  1  qualified by vld_i; final pair of the current dot product.
- clr_i  in  1  discard accumulation in progress and clear ovr_o.
- x_o  out  DATA_W  registered x_i to the east neighbour.
- y_o  out  DATA_W  registered y_i to the south neighbour.
- vld_o  out  1  registered vld_i.
- last_o  out  1  registered last_i.
- res_o  out  ACC_W  completed dot product.
- res_vld_o  out  1  res_o holds an unconsumed result.
- res_rdy_i  in  1  consumer accepts res_o when res_vld_o is high.
- ovf_o  out  1  res_o overflowed the ACC_W range (saturated).
- ovr_o  out  1  sticky: an unconsumed result was overwritten.

Function
REQ-005 x_o, y_o, vld_o and last_o SHALL equal the previous cycle's x_i, y_i, vld_i and last_i, with exactly 1-cycle latency, unconditionally, never stalled by res_rdy_i.
REQ-006 The product x_i*y_i SHALL be formed at full 2*DATA_W width and extended to ACC_W per SIGNED.
REQ-007 The accumulator FSM SHALL have states EMPTY and ACCUM; reset enters EMPTY.
REQ-008 In EMPTY, vld_i&!last_i SHALL load acc with the product and enter ACCUM.
REQ-009 In ACCUM, vld_i&!last_i SHALL add the product to acc and stay in ACCUM.
REQ-010 In either state, vld_i&last_i SHALL load res_o with the final sum (the product alone if EMPTY), set res_vld_o on the next cycle, and enter EMPTY.
REQ-011 Cycles with vld_i low SHALL leave acc and the FSM state unchanged.
REQ-012 Result latency SHALL be 1 cycle: res_vld_o rises on the edge after the last_i beat.
REQ-013 res_vld_o SHALL clear on a cycle with res_vld_o&res_rdy_i unless a new result loads the same cycle, in which case the new result SHALL appear and res_vld_o SHALL stay high with no overrun.
REQ-014 A load while res_vld_o&!res_rdy_i SHALL overwrite res_o and set ovr_o, which SHALL hold until clr_i or rst.
REQ-015 clr_i SHALL force EMPTY and clear ovr_o; a vld_i beat in the same cycle SHALL then be treated as the first beat from EMPTY (REQ-008/REQ-010).
REQ-016 clr_i SHALL NOT affect res_o/res_vld_o or the pass-through outputs.
REQ-017 ovf_o SHALL be registered together with res_o and refer to that result.

Reset
REQ-018 While rst is high, on each rising clk edge the block SHALL set x_o, y_o, vld_o, last_o, res_o, res_vld_o, ovf_o, ovr_o and acc to 0 and the FSM to EMPTY; rst overrides every other input, including during an accumulation.

Configuration
REQ-019 With macro PE_SAT_EN defined, every add SHALL clamp to the ACC_W max/min (per SIGNED), clamped values SHALL persist through later adds, and ovf_o SHALL be 1 for any result that clamped at least once.
REQ-020 Without PE_SAT_EN, adds SHALL wrap modulo 2^ACC_W and ovf_o SHALL be constant 0.

Verification
REQ-021 DATA_W=8, SIGNED=0, res_rdy_i=1: beats (1,2),(3,4),(5,6 last) -> res_o=44, res_vld_o high 1 cycle after the last beat; x_o/y_o trail the inputs by 1 cycle.
REQ-022 SIGNED=1: beats (-3,4),(2,5 last) -> res_o=-2 (two's complement, ACC_W bits).
REQ-023 res_rdy_i=0: two single-beat last results 7*1 then 3*3 -> res_o=9, ovr_o=1; clr_i pulse -> ovr_o=0 while res_o stays 9.
REQ-024 ACC_W=16, SIGNED=0: beats (255,255),(255,255 last) -> with PE_SAT_EN res_o=65535 and ovf_o=1; without it res_o=64514 and ovf_o=0.
REQ-025 rst asserted after 2 of 3 beats, then (2,2 last) -> res_o=4 with no residue, and all outputs read 0 during reset.
REQ-026 res_rdy_i=1 on the cycle a new last beat loads -> new value shown, res_vld_o stays high, ovr_o stays 0.
